syndrome_ctrl: RTL and testbench
================================

// Module: syndrome_ctrl
// PURPOSE
// - Frames incoming RS codewords (BEATS beats x 16 bytes) and sequences the 16-lane syndrome slice bank.
// - Registers each accepted beat toward the slices with its beat index, then captures the final syndromes.
// - Clears the slice accumulators and presents one syndrome vector per codeword via a valid/ready handshake.
// - Sits between the codeword input stream and the key-equation solver.
// PARAMETERS
// - NSYN   16   number of syndromes (slices); out_syn width = NSYN*8
// - BEATS  16   beats per codeword; beat counter width = $clog2(BEATS)
// - DW     128  beat width in bits (16 GF(256) symbols)
// PORTS
// - clk         in   1         clock, all logic on rising edge
// - rst_n       in   1         asynchronous reset, active-low
// - in_data     in   DW        codeword beat
// - in_valid    in   1         beat valid
// - in_sof      in   1         first beat of codeword
// - in_eof      in   1         last beat of codeword
// - in_ready    out  1         beat accepted when in_valid&&in_ready
// - slc_data    out  DW        registered beat to slice bank
// - slc_valid   out  1         slices accumulate slc_data this cycle
// - slc_beat    out  log2(BEATS) beat index of slc_data
// - slc_clr     out  1         synchronous clear of all slice accumulators
// - slc_syn     in   NSYN*8    slice accumulators, packed S0 in [7:0]
// - out_syn     out  NSYN*8    captured syndromes
// - out_valid   out  1         out_syn valid, held until out_ready
// - out_ready   in   1         consumer accepts out_syn
// - out_zero    out  1         all out_syn bytes zero (codeword error-free); valid with out_valid
// - err_frame   out  1         one-cycle pulse: framing violation
// - busy        out  1         state != IDLE or out_valid
// BEHAVIOUR
// - Reset: state=IDLE, beat cnt=0; in_ready=1; slc_valid=0; slc_clr=0; slc_data=0; slc_beat=0.
//   out_syn=0; out_valid=0; out_zero=0; err_frame=0.
// - FSM states:
//   - IDLE: in_ready=1. Accepted beat with in_sof -> RUN, cnt=1. Beat without in_sof -> dropped, err_frame.
//   - RUN: in_ready=1. Each accepted beat increments cnt.
//     - Beat with cnt==BEATS-1 and in_eof -> DRAIN.
//     - Other violations -> err_frame, slc_clr, state IDLE; the offending beat is dropped:
//       in_eof before cnt==BEATS-1; in_eof missing at cnt==BEATS-1; in_sof in RUN.
//   - DRAIN: in_ready=0. Wait one cycle for slice update, then capture -> IDLE.
// - Slice pipeline: beat accepted in cycle n -> slc_valid=1, slc_data, slc_beat=cnt in cycle n+1.
// - Capture: last beat accepted in cycle L -> slc_valid at L+1 -> slc_syn final at L+2.
//   - At L+2, if !out_valid || out_ready: out_syn<=slc_syn, out_valid<=1, slc_clr=1 (same cycle), state IDLE.
//   - Else stay in DRAIN, slc_clr=0, capture on the first cycle the condition holds.
// - Earliest next beat accept: L+3 (in_ready low L+1..L+2). Throughput: BEATS+2 cycles per codeword.
// - out_zero <= (slc_syn==0) at capture.
// - out_valid drops after an out_valid&&out_ready cycle unless a capture occurs in the same cycle (back-to-back).
// - slc_clr never coincides with slc_valid.
// - err_frame is registered: asserted the cycle after the offending beat, for 1 cycle.
// - Reset mid-codeword: all state discarded, no partial out_valid; slices are cleared by their own reset.
// CONFIGURATION
// - SYNDROME_CTRL_STATS_EN defined: adds outputs cw_cnt[15:0], err_cw_cnt[15:0] and frame_err_cnt[15:0].
//   - cw_cnt increments at each capture; err_cw_cnt at captures with out_zero=0; frame_err_cnt per err_frame.
//   - All saturate at 16'hFFFF; reset to 0.
// - SYNDROME_CTRL_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Codeword of 16 all-zero beats (sof beat0, eof beat15), out_ready=1:
//   slc_valid for 16 cycles with slc_beat 0..15; out_valid 3 cycles after eof accept; out_zero=1.
// - Symbol 0x01 at byte 0 of beat 0, rest zero:
//   out_syn equals slice model (S_i = alpha^0 term per lane); out_zero=0; slc_clr pulses once at L+2.
// - Two back-to-back codewords with out_ready=0 until 20 cycles after second eof:
//   second stays in DRAIN, in_ready=0; first popped, second captured same cycle; no data loss.
// - in_eof on beat 5: err_frame pulse, slc_clr, return to IDLE, no out_valid.
//   A non-sof beat in IDLE: dropped, err_frame.
// - Assert rst_n low at beat 8: all outputs return to reset values.
//   A following full codeword produces correct out_syn.
// - With SYNDROME_CTRL_STATS_EN: 3 good + 1 erroneous + 1 framing error -> cw_cnt=4, err_cw_cnt=1, frame_err_cnt=1.

Source files
------------

// File: rtl/syndrome_ctrl.sv
// rtl/syndrome_ctrl.sv - RS codeword framer and syndrome slice-bank sequencer.
// Optional statistics counters are enabled by defining SYNDROME_CTRL_STATS_EN.
module syndrome_ctrl #(
  parameter int NSYN  = 16,
  parameter int BEATS = 16,
  parameter int DW    = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic                     in_eof,
  output logic                     in_ready,
  output logic [DW-1:0]            slc_data,
  output logic                     slc_valid,
  output logic [$clog2(BEATS)-1:0] slc_beat,
  output logic                     slc_clr,
  input  logic [NSYN*8-1:0]        slc_syn,
  output logic [NSYN*8-1:0]        out_syn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_zero,
  output logic                     err_frame,
  output logic                     busy
`ifdef SYNDROME_CTRL_STATS_EN
  ,
  output logic [15:0]              cw_cnt,
  output logic [15:0]              err_cw_cnt,
  output logic [15:0]              frame_err_cnt
`endif
);

  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept, take, viol, viol_run, capture, err_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    viol      = 1'b0;
    viol_run  = 1'b0;
    capture   = 1'b0;
    in_ready  = (state != DRAIN);
    accept    = in_valid && in_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_sof && !in_eof) begin
            take      = 1'b1;
            cnt_nxt   = CW'(1);
            state_nxt = RUN;
          end else begin
            viol = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          // eof must coincide exactly with the last beat; a fresh sof aborts the frame
          if (in_sof || (in_eof != (cnt == LAST))) begin
            viol      = 1'b1;
            viol_run  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            take    = 1'b1;
            cnt_nxt = cnt + CW'(1);
            if (in_eof) state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // slc_valid high means the last beat is still being folded into the slices
        if (!slc_valid && (!out_valid || out_ready)) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    slc_clr = capture || err_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slc_data  <= '0;
      slc_valid <= 1'b0;
      slc_beat  <= '0;
      err_frame <= 1'b0;
      err_clr   <= 1'b0;
      out_syn   <= '0;
      out_valid <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      slc_valid <= take;
      if (take) begin
        slc_data <= in_data;
        slc_beat <= cnt;
      end
      err_frame <= viol;
      // delayed one cycle so the clear cannot land on the preceding beat's slc_valid
      err_clr   <= viol_run;
      if (capture) begin
        out_syn   <= slc_syn;
        out_zero  <= (slc_syn == '0);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) || out_valid;

`ifdef SYNDROME_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_cnt        <= '0;
      err_cw_cnt    <= '0;
      frame_err_cnt <= '0;
    end else begin
      if (capture && cw_cnt != 16'hFFFF) cw_cnt <= cw_cnt + 16'd1;
      if (capture && slc_syn != '0 && err_cw_cnt != 16'hFFFF) err_cw_cnt <= err_cw_cnt + 16'd1;
      if (err_frame && frame_err_cnt != 16'hFFFF) frame_err_cnt <= frame_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_syndrome_ctrl.sv
// tb/tb_syndrome_ctrl.sv - self-checking bench for syndrome_ctrl with a GF(256) slice-bank model.
module tb_syndrome_ctrl;
  localparam int NSYN = 16, BEATS = 16, DW = 128;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_ready;
  logic [DW-1:0] slc_data;
  logic slc_valid, slc_clr;
  logic [3:0] slc_beat;
  logic [NSYN*8-1:0] slc_syn, out_syn;
  logic out_valid, out_zero, err_frame, busy;
  logic out_ready = 1'b0;
`ifdef SYNDROME_CTRL_STATS_EN
  logic [15:0] cw_cnt, err_cw_cnt, frame_err_cnt;
`endif

  syndrome_ctrl #(.NSYN(NSYN), .BEATS(BEATS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_eof(in_eof), .in_ready(in_ready), .slc_data(slc_data), .slc_valid(slc_valid),
    .slc_beat(slc_beat), .slc_clr(slc_clr), .slc_syn(slc_syn), .out_syn(out_syn),
    .out_valid(out_valid), .out_ready(out_ready), .out_zero(out_zero),
    .err_frame(err_frame), .busy(busy)
`ifdef SYNDROME_CTRL_STATS_EN
    , .cw_cnt(cw_cnt), .err_cw_cnt(err_cw_cnt), .frame_err_cnt(frame_err_cnt)
`endif
  );

  typedef logic [7:0] cw_t [256];
  typedef struct { logic [127:0] syn; logic zero; } exp_t;
  typedef struct {
    int mode; int at; int pos; logic [7:0] val;
    int exp_err; int exp_out; logic exp_zero; int exp_nval;
  } vec_t;

  int errors = 0, checks = 0;
  logic [7:0] alog [255];
  exp_t exp_q [$];
  exp_t mon_e;
  int beat_log [$];
  int nval = 0, nclr = 0, nerr = 0, nout = 0, overlap = 0;
  bit rand_ready = 1'b0;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1d) : (x << 1);
    end
    return p;
  endfunction

  // Reference: S_i = sum_j c_j * alpha^(i*(255-j)), symbol j in stream order
  function automatic logic [127:0] ref_syn(input cw_t cw);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < NSYN; i++)
      for (int j = 0; j < 256; j++)
        s[i*8 +: 8] = s[i*8 +: 8] ^ gf_mul(cw[j], alog[(i * (255 - j)) % 255]);
    return s;
  endfunction

  // Slice bank model: each lane folds the 16 symbols of a beat by Horner's rule
  function automatic logic [7:0] horner(input logic [7:0] acc, input logic [7:0] m, input logic [127:0] d);
    logic [7:0] a;
    a = acc;
    for (int k = 0; k < 16; k++) a = gf_mul(a, m) ^ d[k*8 +: 8];
    return a;
  endfunction

  logic [7:0] syn_acc [NSYN];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYN; i++) syn_acc[i] <= 8'h00;
    end else if (slc_clr) begin
      for (int i = 0; i < NSYN; i++) syn_acc[i] <= 8'h00;
    end else if (slc_valid) begin
      for (int i = 0; i < NSYN; i++) syn_acc[i] <= horner(syn_acc[i], alog[i], slc_data);
    end
  end
  always_comb begin
    slc_syn = '0;
    for (int i = 0; i < NSYN; i++) slc_syn[i*8 +: 8] = syn_acc[i];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (slc_valid) begin nval++; beat_log.push_back(int'(slc_beat)); end
    if (slc_clr) nclr++;
    if (err_frame) nerr++;
    if (slc_clr && slc_valid) overlap++;
    if (out_valid && out_ready) begin
      nout++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got out_syn %h expected no output", out_syn);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_syn", out_syn, mon_e.syn);
        chk("out_zero", 128'(out_zero), 128'(mon_e.zero));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [127:0] d, input logic sof, input logic eof);
    int n;
    n = 0;
    in_data = d; in_sof = sof; in_eof = eof; in_valid = 1'b1;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL in_ready_wait: got in_ready low for %0d cycles expected high", n);
    end
    tick();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  // mode 0 good, 1 eof at beat 'at', 2 no eof on last beat, 3 sof at beat 'at', 4 lone non-sof beat
  task automatic send_cw(input cw_t cw, input int mode, input int at, input bit gaps);
    int last;
    logic [127:0] d, s;
    if (mode == 0) begin
      s = ref_syn(cw);
      exp_q.push_back('{syn: s, zero: (s == '0)});
    end
    last = (mode == 0 || mode == 2) ? 15 : ((mode == 4) ? 0 : at);
    for (int b = 0; b <= last; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      for (int k = 0; k < 16; k++) d[k*8 +: 8] = cw[b*16 + k];
      send_beat(d, (mode != 4 && b == 0) || (mode == 3 && b == at),
                (mode == 0 && b == 15) || (mode == 1 && b == at));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    if (!rand_ready) out_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 400) begin tick(); n++; end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL idle_wait: got busy=%0d pending=%0d expected idle", busy, exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_slc_valid"}, 128'(slc_valid), 128'(0));
    chk({tag, "_slc_clr"}, 128'(slc_clr), 128'(0));
    chk({tag, "_slc_data"}, slc_data, 128'(0));
    chk({tag, "_slc_beat"}, 128'(slc_beat), 128'(0));
    chk({tag, "_out_syn"}, out_syn, 128'(0));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_out_zero"}, 128'(out_zero), 128'(0));
    chk({tag, "_err_frame"}, 128'(err_frame), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    cw_t cw;
    vec_t tbl [8];
    int e0, o0, v0, c0;
    logic [127:0] ones;

    alog[0] = 8'h01;
    for (int k = 1; k < 255; k++) alog[k] = gf_mul(alog[k-1], 8'h02);

    tbl[0] = '{0, 0,   0, 8'h00, 0, 1, 1'b1, 16};
    tbl[1] = '{0, 0,   0, 8'h01, 0, 1, 1'b0, 16};
    tbl[2] = '{0, 0, 255, 8'hA5, 0, 1, 1'b0, 16};
    tbl[3] = '{1, 5,   0, 8'h00, 1, 0, 1'b0, 5};
    tbl[4] = '{2, 0,   0, 8'h00, 1, 0, 1'b0, 15};
    tbl[5] = '{3, 7,  17, 8'h3C, 1, 0, 1'b0, 7};
    tbl[6] = '{4, 0,   0, 8'h00, 1, 0, 1'b0, 0};
    tbl[7] = '{1, 1,   0, 8'h00, 1, 0, 1'b0, 1};

    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // First-codeword latency and slice handshake timing
    out_ready = 1'b1;
    for (int j = 0; j < 256; j++) cw[j] = 8'h00;
    beat_log.delete();
    send_cw(cw, 0, 0, 1'b0);
    chk("L1_in_ready", 128'(in_ready), 128'(0));
    chk("L1_slc_beat", 128'(slc_beat), 128'(15));
    chk("L1_slc_clr", 128'(slc_clr), 128'(0));
    chk("L1_out_valid", 128'(out_valid), 128'(0));
    tick();
    chk("L2_in_ready", 128'(in_ready), 128'(0));
    chk("L2_slc_clr", 128'(slc_clr), 128'(1));
    chk("L2_out_valid", 128'(out_valid), 128'(0));
    tick();
    chk("L3_out_valid", 128'(out_valid), 128'(1));
    chk("L3_out_zero", 128'(out_zero), 128'(1));
    chk("L3_in_ready", 128'(in_ready), 128'(1));
    chk("L3_slc_clr", 128'(slc_clr), 128'(0));
    wait_idle();
    chk("slc_beat_count", 128'(beat_log.size()), 128'(16));
    for (int i = 0; i < beat_log.size() && i < 16; i++) chk("slc_beat_seq", 128'(beat_log[i]), 128'(i));

    // Unit symbol at stream position 0: every syndrome equals alpha^255 = 1
    cw[0] = 8'h01;
    c0 = nclr;
    ones = {16{8'h01}};
    send_cw(cw, 0, 0, 1'b0);
    tick(); tick();
    chk("unit_out_syn", out_syn, ones);
    chk("unit_out_zero", 128'(out_zero), 128'(0));
    wait_idle();
    chk("unit_clr_pulses", 128'(nclr - c0), 128'(1));

    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < 256; j++) cw[j] = 8'h00;
      cw[tbl[t].pos] = tbl[t].val;
      e0 = nerr; o0 = nout; v0 = nval; c0 = nclr;
      send_cw(cw, tbl[t].mode, tbl[t].at, 1'b0);
      wait_idle();
      chk("tbl_err_frame", 128'(nerr - e0), 128'(tbl[t].exp_err));
      chk("tbl_out_count", 128'(nout - o0), 128'(tbl[t].exp_out));
      chk("tbl_slc_valid", 128'(nval - v0), 128'(tbl[t].exp_nval));
      if (tbl[t].mode != 4) chk("tbl_slc_clr", 128'(nclr - c0), 128'(1));
      if (tbl[t].exp_out != 0) chk("tbl_out_zero", 128'(out_zero), 128'(tbl[t].exp_zero));
    end

    // Back-to-back codewords with the consumer stalled
    out_ready = 1'b0;
    o0 = nout;
    for (int j = 0; j < 256; j++) cw[j] = 8'($urandom);
    send_cw(cw, 0, 0, 1'b0);
    for (int j = 0; j < 256; j++) cw[j] = 8'($urandom);
    send_cw(cw, 0, 0, 1'b0);
    repeat (19) tick();
    chk("b2b_in_ready", 128'(in_ready), 128'(0));
    chk("b2b_out_valid", 128'(out_valid), 128'(1));
    chk("b2b_busy", 128'(busy), 128'(1));
    chk("b2b_no_pop", 128'(nout - o0), 128'(0));
    out_ready = 1'b1;
    tick();
    chk("b2b_second_valid", 128'(out_valid), 128'(1));
    chk("b2b_in_ready_back", 128'(in_ready), 128'(1));
    tick();
    chk("b2b_pops", 128'(nout - o0), 128'(2));
    chk("b2b_drained", 128'(out_valid), 128'(0));

    // Reset in the middle of a codeword
    for (int j = 0; j < 256; j++) cw[j] = 8'($urandom);
    for (int b = 0; b < 8; b++) send_beat({$urandom, $urandom, $urandom, $urandom}, b == 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    o0 = nout;
    send_cw(cw, 0, 0, 1'b0);
    wait_idle();
    chk("midrst_out_count", 128'(nout - o0), 128'(1));

    // Randomized codewords, gaps and back-pressure against the reference model
    rand_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      int r;
      r = $urandom_range(0, 3);
      for (int j = 0; j < 256; j++)
        cw[j] = (r != 0 && $urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 5) == 0) send_cw(cw, 1, $urandom_range(1, 14), 1'b1);
      else send_cw(cw, 0, 0, 1'b1);
    end
    rand_ready = 1'b0;
    wait_idle();
    chk("scoreboard_drain", 128'(exp_q.size()), 128'(0));

`ifdef SYNDROME_CTRL_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int j = 0; j < 256; j++) cw[j] = 8'h00;
    repeat (3) begin send_cw(cw, 0, 0, 1'b0); wait_idle(); end
    cw[40] = 8'h77;
    send_cw(cw, 0, 0, 1'b0); wait_idle();
    send_cw(cw, 1, 5, 1'b0); wait_idle();
    chk("stats_cw_cnt", 128'(cw_cnt), 128'(4));
    chk("stats_err_cw_cnt", 128'(err_cw_cnt), 128'(1));
    chk("stats_frame_err_cnt", 128'(frame_err_cnt), 128'(1));
`endif

    chk("clr_valid_overlap", 128'(overlap), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
